tree_sum_sequencer: RTL and testbench
=====================================

Name: tree_sum_sequencer

Overview:
- Controls one pipelined, non-stallable adder tree (one 4096-lane partial sum per cycle) so it can compute a dot product longer than the tree width.
- Accepts a chunk count per vector and gates chunk issue into the tree with a valid/ready handshake.
- Tracks each chunk through the tree latency with a tag pipeline and accumulates the tree outputs into one signed result per vector.
- Presents the result on a valid/ready output port; sits between the layer input buffer and the ternary vector multiplier result path.

Parameters:
- TREE_LAT, 13, cycles from chunk issue to the matching tree_sum (12 adder levels + output register); legal ≥1.
- SUM_W, 20, width of the tree output (signed).
- ACC_W, 32, accumulator/result width (signed); legal ≥ SUM_W.
- LEN_W, 16, width of the chunk-count configuration.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a vector; sampled only in IDLE
- cfg_chunks  in  LEN_W  chunks in this vector; latched on accepted start
- busy  out  1  high in every state except IDLE
- in_valid  in  1  upstream chunk present at tree inputs
- in_ready  out  1  sequencer accepts a chunk this cycle
- tree_load  out  1  = in_valid & in_ready; chunk enters tree this edge
- tree_sum  in  SUM_W  tree output, signed
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- acc_out  out  ACC_W  signed result
- ovf  out  1  sticky: signed overflow occurred in this vector's accumulation

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, in_ready, tree_load, out_valid, ovf = 0; acc_out=0.
  - Tag pipeline cleared and issue counter = 0.
  - Results still inside the tree at reset are discarded, because their tags are gone.
- Tag pipeline: TREE_LAT stages of {v, first, last}.
  - Stage 0 loads {tree_load, issue_cnt==0, issue_cnt==chunks−1}.
  - Stage TREE_LAT−1 qualifies tree_sum in the same cycle.
- FSM:
  - IDLE: in_ready=0. If start=1 and cfg_chunks≠0, latch chunks, clear issue_cnt and ovf, go to RUN. start with cfg_chunks=0 is ignored and the block stays IDLE.
  - RUN: in_ready=1. Each tree_load increments issue_cnt. Gaps (in_valid=0) are allowed. On the load of the last chunk, go to DRAIN the next cycle.
  - DRAIN: in_ready=0. Waits for the tag with last=1 to reach the output stage.
  - DONE: out_valid=1, acc_out stable. On out_ready=1 go to IDLE, out_valid falls next cycle.
  - start outside IDLE is ignored.
- Accumulation on each qualified tree_sum, with s = sign-extended tree_sum:
  - If tag.first: acc ← s.
  - Else: acc ← acc + s, wrapping two's complement at ACC_W.
  - ovf is set when the operands share a sign and the sum's sign differs. ovf stays set until the next accepted start.
- Completion:
  - When the qualified tag has last=1, that accumulation is written to acc_out and the state moves to DONE on the same edge.
  - out_valid first seen high TREE_LAT+1 cycles after the edge that loaded the last chunk.
- chunks=1: the single tag carries first=last=1; acc_out = sext(tree_sum).
- Only one vector is in flight, so the tree never holds tags of two vectors. Downstream stall in DONE is therefore safe despite the non-stallable tree.
- Unqualified tree_sum values (v=0) never alter acc_out.
- Reset mid-RUN or mid-DRAIN: immediate return to IDLE, no out_valid pulse.

Test Plan:
- Bench model: tree replaced by a TREE_LAT=13 delay line.
- Single chunk: start, cfg_chunks=1, in_valid held 1, tree value 100 → exactly one tree_load; out_valid rises 14 cycles after the load edge; acc_out=100; ovf=0.
- Back-to-back 4 chunks, values 5, −3, 7, −9 → 4 consecutive tree_loads; in_ready low after the 4th; acc_out=0; DONE holds until out_ready=1.
- Bubbled input: cfg_chunks=3, in_valid pattern 1,0,0,1,0,1 with values 524287, 524287, −1 → acc_out=1048573; bubble cycles do not count.
- Overflow, ACC_W=20: two chunks of 524287 → acc_out wraps to −2, ovf=1. Next vector with 1 chunk of 3 → ovf=0, acc_out=3.
- Backpressure and ignored starts: out_ready=0 for 20 cycles in DONE → acc_out and out_valid stable, start pulses ignored. start with cfg_chunks=0 in IDLE → busy stays 0.
- Reset mid-DRAIN: rst_n low 2 cycles after the last load, then a new vector with cfg_chunks=1 and value 42 → stale in-flight sums are ignored; acc_out=42.

Source files
------------

// File: rtl/tree_sum_sequencer.sv
// Sequences chunked dot products through a fixed-latency, non-stallable adder tree
// and accumulates the tree outputs into one signed result per vector.
module tree_sum_sequencer #(
  parameter int TREE_LAT = 13,
  parameter int SUM_W    = 20,
  parameter int ACC_W    = 32,
  parameter int LEN_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        cfg_chunks,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    tree_load,
  input  logic signed [SUM_W-1:0] tree_sum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [LEN_W-1:0]        chunks_q, chunks_d;
  logic [LEN_W-1:0]        issue_cnt_q, issue_cnt_d;
  logic [TREE_LAT-1:0]     tag_v_q, tag_v_d;
  logic [TREE_LAT-1:0]     tag_first_q, tag_first_d;
  logic [TREE_LAT-1:0]     tag_last_q, tag_last_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic                    ovf_q, ovf_d;

  logic signed [ACC_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    qual;
  logic                    add_ovf;

  assign in_ready  = (state_q == S_RUN);
  assign tree_load = in_valid & in_ready;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign acc_out   = acc_out_q;
  assign ovf       = ovf_q;

  // The output-stage tag qualifies whatever the tree presents this cycle.
  assign qual    = tag_v_q[TREE_LAT-1];
  assign sum_ext = ACC_W'(tree_sum);
  assign acc_sum = acc_q + sum_ext;
  assign add_ovf = (acc_q[ACC_W-1] == sum_ext[ACC_W-1]) &&
                   (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    tag_v_d        = '0;
    tag_first_d    = '0;
    tag_last_d     = '0;
    tag_v_d[0]     = tree_load;
    tag_first_d[0] = (issue_cnt_q == '0);
    tag_last_d[0]  = (issue_cnt_q == chunks_q - LEN_W'(1));
    for (int unsigned i = 1; i < TREE_LAT; i++) begin
      tag_v_d[i]     = tag_v_q[i-1];
      tag_first_d[i] = tag_first_q[i-1];
      tag_last_d[i]  = tag_last_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    chunks_d    = chunks_q;
    issue_cnt_d = issue_cnt_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    ovf_d       = ovf_q;

    if (qual) begin
      if (tag_first_q[TREE_LAT-1]) begin
        acc_d = sum_ext;
      end else begin
        acc_d = acc_sum;
        if (add_ovf) ovf_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && (cfg_chunks != '0)) begin
          chunks_d    = cfg_chunks;
          issue_cnt_d = '0;
          ovf_d       = 1'b0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (tree_load) begin
          issue_cnt_d = issue_cnt_q + LEN_W'(1);
          if (issue_cnt_q == chunks_q - LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (qual && tag_last_q[TREE_LAT-1]) begin
          acc_out_d = acc_d;
          state_d   = S_DONE;
        end
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      chunks_q    <= '0;
      issue_cnt_q <= '0;
      tag_v_q     <= '0;
      tag_first_q <= '0;
      tag_last_q  <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      chunks_q    <= chunks_d;
      issue_cnt_q <= issue_cnt_d;
      tag_v_q     <= tag_v_d;
      tag_first_q <= tag_first_d;
      tag_last_q  <= tag_last_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_tree_sum_sequencer.sv
// Directed bench for tree_sum_sequencer: a delay line stands in for the adder tree,
// and two instances (32-bit and 20-bit accumulators) share the same stimulus.
module tb_tree_sum_sequencer;

  localparam int LAT = 13;
  localparam logic signed [19:0] GARB = 20'sd12345;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, out_ready;
  logic [15:0] cfg_chunks;
  logic signed [19:0] tree_in, tree_sum;
  logic signed [19:0] dl [LAT];

  logic busy32, in_ready32, tree_load32, out_valid32, ovf32;
  logic signed [31:0] acc32;
  logic busy20, in_ready20, tree_load20, out_valid20, ovf20;
  logic signed [19:0] acc20;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    int         n;
    int         vals [4];
    logic [7:0] pat;
    int         exp_acc32;
    logic       exp_ovf32;
    int         exp_acc20;
    logic       exp_ovf20;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dl[0] <= tree_in;
    for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
  end
  assign tree_sum = dl[LAT-1];

  tree_sum_sequencer #(.TREE_LAT(13), .SUM_W(20), .ACC_W(32), .LEN_W(16)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_chunks(cfg_chunks), .busy(busy32),
    .in_valid(in_valid), .in_ready(in_ready32), .tree_load(tree_load32), .tree_sum(tree_sum),
    .out_valid(out_valid32), .out_ready(out_ready), .acc_out(acc32), .ovf(ovf32));

  tree_sum_sequencer #(.TREE_LAT(13), .SUM_W(20), .ACC_W(20), .LEN_W(16)) u20 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_chunks(cfg_chunks), .busy(busy20),
    .in_valid(in_valid), .in_ready(in_ready20), .tree_load(tree_load20), .tree_sum(tree_sum),
    .out_valid(out_valid20), .out_ready(out_ready), .acc_out(acc20), .ovf(ovf20));

  function automatic logic [31:0] sx20(input logic [19:0] v);
    return 32'($signed(v));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, $signed(act), act,
               $signed(exp), exp);
    end
  endtask

  // Waits at most 40 cycles for out_valid; cnt counts negedges from the load cycle.
  task automatic wait_done(output int cnt, output logic extra);
    cnt = 0;
    extra = 1'b0;
    while (cnt < 40) begin
      @(negedge clk);
      in_valid = 1'b1;
      tree_in  = GARB;
      cnt++;
      #1;
      if (tree_load32 || tree_load20) extra = 1'b1;
      if (out_valid32) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t t);
    int loads, slot, cnt;
    logic extra, ld_bad;
    @(negedge clk);
    start = 1'b1;
    cfg_chunks = 16'(t.n);
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({t.name, ":busy"}, 32'(busy32 & busy20), 32'd1);
    loads = 0;
    slot = 0;
    ld_bad = 1'b0;
    while (loads < t.n && slot < 8) begin
      in_valid = t.pat[slot];
      tree_in  = t.pat[slot] ? 20'(t.vals[loads]) : GARB;
      #1;
      if (tree_load32 !== t.pat[slot] || tree_load20 !== t.pat[slot]) ld_bad = 1'b1;
      if (t.pat[slot]) loads++;
      slot++;
      if (loads < t.n) @(negedge clk);
    end
    chk({t.name, ":loads"}, 32'(loads), 32'(t.n));
    chk({t.name, ":tree_load"}, 32'(ld_bad), 32'd0);
    wait_done(cnt, extra);
    chk({t.name, ":latency"}, 32'(cnt), 32'(LAT + 1));
    chk({t.name, ":extra_load"}, 32'(extra), 32'd0);
    chk({t.name, ":valid20"}, 32'(out_valid20), 32'd1);
    chk({t.name, ":acc32"}, acc32, 32'(t.exp_acc32));
    chk({t.name, ":ovf32"}, 32'(ovf32), 32'(t.exp_ovf32));
    chk({t.name, ":acc20"}, sx20(acc20), 32'(t.exp_acc20));
    chk({t.name, ":ovf20"}, 32'(ovf20), 32'(t.exp_ovf20));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({t.name, ":release"}, 32'(out_valid32 | out_valid20 | busy32 | busy20), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic extra, bad;
    vec_t t;

    tbl[0] = '{"single",   1, '{100, 0, 0, 0},               8'h01, 100,      1'b0, 100,     1'b0};
    tbl[1] = '{"four",     4, '{5, -3, 7, -9},               8'h0F, 0,        1'b0, 0,       1'b0};
    tbl[2] = '{"bubbled",  3, '{524287, 524287, -1, 0},      8'h29, 1048573,  1'b0, -3,      1'b1};
    tbl[3] = '{"ovf_pos",  2, '{524287, 524287, 0, 0},       8'h03, 1048574,  1'b0, -2,      1'b1};
    tbl[4] = '{"ovf_clr",  1, '{3, 0, 0, 0},                 8'h01, 3,        1'b0, 3,       1'b0};
    tbl[5] = '{"ovf_neg",  2, '{-524288, -524288, 0, 0},     8'h03, -1048576, 1'b0, 0,       1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    cfg_chunks = '0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tree_in = GARB;
    @(negedge clk);
    @(negedge clk);
    chk("rst:busy", 32'(busy32 | busy20), 32'd0);
    chk("rst:ready_load", 32'(in_ready32 | tree_load32 | in_ready20 | tree_load20), 32'd0);
    chk("rst:valid_ovf", 32'(out_valid32 | ovf32 | out_valid20 | ovf20), 32'd0);
    chk("rst:acc", acc32 | sx20(acc20), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // start with zero chunks must be ignored
    @(negedge clk);
    start = 1'b1;
    cfg_chunks = '0;
    in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("zero_cfg:busy", 32'(busy32 | busy20 | in_ready32 | tree_load32), 32'd0);
    @(negedge clk);
    chk("zero_cfg:busy_later", 32'(busy32 | busy20), 32'd0);
    in_valid = 1'b0;

    // Backpressure in DONE with stray starts
    @(negedge clk);
    start = 1'b1;
    cfg_chunks = 16'd1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    tree_in = 20'sd77;
    wait_done(cnt, extra);
    chk("bp:latency", 32'(cnt), 32'(LAT + 1));
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = i[0];
      cfg_chunks = 16'd2;
      in_valid = 1'b1;
      #1;
      if (out_valid32 !== 1'b1 || acc32 !== 32'sd77 || in_ready32 !== 1'b0 ||
          tree_load32 !== 1'b0 || out_valid20 !== 1'b1) bad = 1'b1;
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("bp:stable", 32'(bad), 32'd0);
    chk("bp:acc", acc32, 32'd77);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp:release", 32'(out_valid32 | busy32), 32'd0);
    @(negedge clk);
    chk("bp:no_restart", 32'(busy32 | busy20), 32'd0);

    // Reset two cycles into DRAIN, then a fresh single-chunk vector
    start = 1'b1;
    cfg_chunks = 16'd2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    tree_in = 20'sd1000;
    @(negedge clk);
    tree_in = 20'sd2000;
    @(negedge clk);
    in_valid = 1'b0;
    tree_in = GARB;
    @(negedge clk);
    chk("rstd:draining", 32'(busy32 & ~in_ready32), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstd:idle", 32'(busy32 | out_valid32 | busy20 | out_valid20), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t = '{"after_rst", 1, '{42, 0, 0, 0}, 8'h01, 42, 1'b0, 42, 1'b0};
    run_vec(t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
